// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single shared memory port.
// Optional macro MEM_BUS_ARB_RR_EN: round-robin on contention instead of data-over-fetch priority.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ready_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_sel_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ready_o,
    output logic        bus_ce_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_req_o,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;   // 1 = data port, 0 = fetch port
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] d_data_q, d_data_d;
    logic        pick_data;
    logic        in_access;

`ifdef MEM_BUS_ARB_RR_EN
    logic        last_q, last_d;     // 1 = data was granted most recently

    // On contention the port that did not win last time is served.
    assign pick_data = d_req_i & (~if_req_i | ~last_q);
`else
    assign pick_data = d_req_i;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        we_d      = we_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        if_data_d = if_data_q;
        d_data_d  = d_data_q;
`ifdef MEM_BUS_ARB_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (if_req_i || d_req_i) begin
                    state_d = S_ACCESS;
                    cnt_d   = WAIT_LD;
                    grant_d = pick_data;
`ifdef MEM_BUS_ARB_RR_EN
                    last_d  = pick_data;
`endif
                    if (pick_data) begin
                        we_d    = d_we_i;
                        addr_d  = d_addr_i;
                        sel_d   = d_sel_i;
                        wdata_d = d_wdata_i;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = if_addr_i;
                        sel_d   = 4'b1111;
                        wdata_d = 32'h0;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        if (grant_q) d_data_d  = bus_rdata_i;
                        else         if_data_d = bus_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            grant_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            sel_q     <= 4'h0;
            wdata_q   <= 32'h0;
            if_data_q <= 32'h0;
            d_data_q  <= 32'h0;
`ifdef MEM_BUS_ARB_RR_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            if_data_q <= if_data_d;
            d_data_q  <= d_data_d;
`ifdef MEM_BUS_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign in_access   = (state_q == S_ACCESS);
    assign bus_ce_o    = in_access;
    assign bus_we_o    = in_access & we_q;
    assign bus_sel_o   = in_access ? sel_q   : 4'h0;
    assign bus_addr_o  = in_access ? addr_q  : 32'h0;
    assign bus_wdata_o = in_access ? wdata_q : 32'h0;
    assign if_ready_o  = (state_q == S_DONE) & ~grant_q;
    assign d_ready_o   = (state_q == S_DONE) & grant_q;
    assign if_data_o   = if_data_q;
    assign d_rdata_o   = d_data_q;
    assign dbg_state_o = state_q;

    // Held low during reset so every output reads 0 while rst is asserted.
    assign stall_req_o = rst & ((if_req_i & ~if_ready_o) | (d_req_i & ~d_ready_o));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter plus a WAIT_CYCLES=0 directed instance.
module tb_mem_bus_arbiter;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_req_i = 0, d_req_i = 0, d_we_i = 0;
  logic [31:0] if_addr_i = 0, d_addr_i = 0, d_wdata_i = 0, bus_rdata_i = 0;
  logic [3:0]  d_sel_i = 0;
  logic [31:0] if_data_o, d_rdata_o, bus_addr_o, bus_wdata_o;
  logic        if_ready_o, d_ready_o, bus_ce_o, bus_we_o, stall_req_o;
  logic [3:0]  bus_sel_o;
  logic [1:0]  dbg_state_o;

  logic        z_d_req_i = 0;
  logic [31:0] z_if_data_o, z_d_rdata_o, z_bus_addr_o, z_bus_wdata_o, z_bus_rdata_i;
  logic        z_if_ready_o, z_d_ready_o, z_bus_ce_o, z_bus_we_o, z_stall_req_o;
  logic [3:0]  z_bus_sel_o;
  logic [1:0]  z_dbg_state_o;

  mem_bus_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_sel_i(d_sel_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .stall_req_o(stall_req_o), .dbg_state_o(dbg_state_o)
  );

  assign z_bus_rdata_i = z_bus_ce_o ? 32'h12345678 : 32'hBAD0BAD0;

  mem_bus_arbiter #(.WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .if_req_i(1'b0), .if_addr_i(32'h0), .if_data_o(z_if_data_o), .if_ready_o(z_if_ready_o),
    .d_req_i(z_d_req_i), .d_we_i(1'b0), .d_addr_i(32'h80), .d_wdata_i(32'h0),
    .d_sel_i(4'b1111), .d_rdata_o(z_d_rdata_o), .d_ready_o(z_d_ready_o),
    .bus_ce_o(z_bus_ce_o), .bus_we_o(z_bus_we_o), .bus_addr_o(z_bus_addr_o), .bus_sel_o(z_bus_sel_o),
    .bus_wdata_o(z_bus_wdata_o), .bus_rdata_i(z_bus_rdata_i),
    .stall_req_o(z_stall_req_o), .dbg_state_o(z_dbg_state_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {logic is_d; int t; logic [31:0] e_if; logic [31:0] e_d;} rdy_t;
  typedef struct {logic we; logic [31:0] addr; logic [3:0] sel; logic [31:0] wdata;} bus_t;
  rdy_t rdy_q[$];
  bus_t bus_q[$];
  rdy_t mon_e;
  bus_t mon_b;
  int   acc_cnt = 0;

  // Reference model state: last read value per port and which port won last.
  logic [31:0] m_if = 0, m_d = 0;
  logic        m_last_d = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h100) return 32'h3C010001;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: ready pulses against the expected-response queue, bus activity against the access queue.
  always @(negedge clk) begin
    if (if_ready_o || d_ready_o) begin
      if (rdy_q.size() == 0) begin
        chk("spurious_ready", {30'b0, if_ready_o, d_ready_o}, 32'h0);
      end else begin
        mon_e = rdy_q.pop_front();
        chk("ready_port", {30'b0, if_ready_o, d_ready_o}, mon_e.is_d ? 32'h1 : 32'h2);
        chk("ready_cycle", cyc, mon_e.t);
        chk("if_data", if_data_o, mon_e.e_if);
        chk("d_rdata", d_rdata_o, mon_e.e_d);
      end
    end
    if (bus_ce_o) begin
      if (bus_q.size() == 0) begin
        chk("spurious_ce", {31'b0, bus_ce_o}, 32'h0);
        bus_rdata_i = 32'hBAD0BAD0;
      end else begin
        mon_b = bus_q[0];
        chk("bus_we", {31'b0, bus_we_o}, {31'b0, mon_b.we});
        chk("bus_addr", bus_addr_o, mon_b.addr);
        chk("bus_sel", {28'b0, bus_sel_o}, {28'b0, mon_b.sel});
        if (mon_b.we) chk("bus_wdata", bus_wdata_o, mon_b.wdata);
        acc_cnt++;
        // Read data is only valid on the final access cycle.
        if (acc_cnt == W + 1) begin
          bus_rdata_i = mem_f(mon_b.addr);
          void'(bus_q.pop_front());
          acc_cnt = 0;
        end else begin
          bus_rdata_i = ~mem_f(mon_b.addr);
        end
      end
    end else begin
      chk("bus_idle", {27'b0, bus_we_o, bus_sel_o} | bus_addr_o | bus_wdata_o, 32'h0);
      bus_rdata_i = 32'hBAD0BAD0;
    end
  end

  task automatic push_access(input logic is_d, input int t, input logic [31:0] fa,
                             input logic dwe, input logic [31:0] da, input logic [3:0] ds,
                             input logic [31:0] dw);
    bus_t b;
    rdy_t r;
    if (is_d) begin
      b = '{we: dwe, addr: da, sel: ds, wdata: dw};
      if (!dwe) m_d = mem_f(da);
    end else begin
      b = '{we: 1'b0, addr: fa, sel: 4'b1111, wdata: 32'h0};
      m_if = mem_f(fa);
    end
    m_last_d = is_d;
    r = '{is_d: is_d, t: t, e_if: m_if, e_d: m_d};
    bus_q.push_back(b);
    rdy_q.push_back(r);
  endtask

  task automatic rand_idle_ops();
    if (!if_req_i) if_addr_i = $urandom;
    if (!d_req_i) begin
      d_addr_i  = $urandom;
      d_wdata_i = $urandom;
      d_we_i    = 1'($urandom_range(0, 1));
      d_sel_i   = 4'($urandom_range(0, 15));
    end
  endtask

  // Called at posedge+1 of a cycle with the arbiter idle.
  task automatic episode(input bit do_f, input bit do_d, input bit drop, input logic [31:0] fa,
                         input logic dwe, input logic [31:0] da, input logic [3:0] ds,
                         input logic [31:0] dw);
    int  start, tf, td, tend;
    bit  d_first, f_act, d_act;
    start = cyc;
    if_req_i = do_f;
    d_req_i  = do_d;
    if (do_f) if_addr_i = fa;
    if (do_d) begin
      d_we_i = dwe; d_addr_i = da; d_sel_i = ds; d_wdata_i = dw;
    end
    rand_idle_ops();
`ifdef MEM_BUS_ARB_RR_EN
    d_first = do_d && (!do_f || !m_last_d);
`else
    d_first = do_d;
`endif
    tf = 0;
    td = 0;
    if (d_first) begin
      td = start + W + 2;
      push_access(1'b1, td, fa, dwe, da, ds, dw);
      if (do_f) begin
        tf = start + 2 * W + 5;
        push_access(1'b0, tf, fa, dwe, da, ds, dw);
      end
    end else begin
      tf = start + W + 2;
      push_access(1'b0, tf, fa, dwe, da, ds, dw);
      if (do_d) begin
        td = start + 2 * W + 5;
        push_access(1'b1, td, fa, dwe, da, ds, dw);
      end
    end
    tend = (tf > td) ? tf : td;
    for (int c = start; c <= tend; c++) begin
      @(negedge clk);
      f_act = do_f && (c < tf) && !(drop && c >= start + 2);
      d_act = do_d && (c < td) && !(drop && c >= start + 2);
      chk("stall", {31'b0, stall_req_o}, {31'b0, f_act || d_act});
      @(posedge clk);
      #1;
      if (c + 1 > tf) if_req_i = 1'b0;
      if (c + 1 > td) d_req_i = 1'b0;
      if (drop && c + 1 == start + 2) begin
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
      end
      rand_idle_ops();
    end
    chk("ready_seen", rdy_q.size(), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ce_we_sel_rdy"}, {26'b0, bus_ce_o, bus_we_o, bus_sel_o}
        | {30'b0, if_ready_o, d_ready_o}, 32'h0);
    chk({tag, "_addr_wdata"}, bus_addr_o | bus_wdata_o, 32'h0);
    chk({tag, "_data_regs"}, if_data_o | d_rdata_o, 32'h0);
    chk({tag, "_stall"}, {31'b0, stall_req_o}, 32'h0);
    chk({tag, "_state"}, {30'b0, dbg_state_o}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit        kind_f, kind_d, drop;
    int        k;
    logic [31:0] ra;
    if_req_i = 1'b1;
    d_req_i  = 1'b1;
    #1;
    check_reset_outputs("reset");
    chk("z_reset", {26'b0, z_bus_ce_o, z_d_ready_o, z_if_ready_o, z_stall_req_o, z_dbg_state_o}
        | z_d_rdata_o | z_if_data_o, 32'h0);
    if_req_i = 1'b0;
    d_req_i  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // WAIT_CYCLES=0 load from 0x80.
    z_d_req_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("z_bus_ce", {31'b0, z_bus_ce_o}, {31'b0, c == 1});
      chk("z_d_ready", {31'b0, z_d_ready_o}, {31'b0, c == 2});
      if (c == 1) chk("z_bus_addr", z_bus_addr_o, 32'h80);
      if (c == 2) chk("z_d_rdata", z_d_rdata_o, 32'h12345678);
      @(posedge clk); #1;
      if (c >= 2) z_d_req_i = 1'b0;
    end
    chk("z_d_rdata_hold", z_d_rdata_o, 32'h12345678);

    // Directed: single fetch, data store, contention, data load.
    episode(1, 0, 0, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0);
    episode(0, 1, 0, 32'h0, 1'b1, 32'h40, 4'b0011, 32'hBEEF);
    episode(1, 1, 0, 32'h200, 1'b0, 32'h300, 4'b1111, 32'h0);
    episode(1, 1, 0, 32'h204, 1'b1, 32'h304, 4'b1100, 32'hCAFE0000);

    // Reset in the middle of an access.
    if_req_i  = 1'b1;
    if_addr_i = 32'h500;
    bus_q.push_back('{we: 1'b0, addr: 32'h500, sel: 4'b1111, wdata: 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    bus_q.delete();
    rdy_q.delete();
    acc_cnt  = 0;
    m_if     = 32'h0;
    m_d      = 32'h0;
    m_last_d = 1'b0;
    if_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    episode(1, 0, 0, 32'h600, 1'b0, 32'h0, 4'h0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      k      = $urandom_range(0, 2);
      kind_f = (k != 1);
      kind_d = (k != 0);
      drop   = (k != 2) && ($urandom_range(0, 3) == 0);
      ra     = $urandom;
      episode(kind_f, kind_d, drop, $urandom, 1'($urandom_range(0, 1)), ra,
              4'($urandom_range(1, 15)), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        rand_idle_ops();
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_queues_empty", rdy_q.size() + bus_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning extra bus cycles per access; legal range 0..15.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports if_req_i input 1, if_addr_i input 32, if_data_o output 32, if_ready_o output 1; this is the instruction-fetch requester.
REQ-005 SHALL have ports d_req_i input 1, d_we_i input 1, d_addr_i input 32, d_wdata_i input 32, d_sel_i input 4, d_rdata_o output 32, d_ready_o output 1; this is the data (load/store) requester.
REQ-006 SHALL have ports bus_ce_o output 1, bus_we_o output 1, bus_addr_o output 32, bus_sel_o output 4, bus_wdata_o output 32, bus_rdata_i input 32; this is the single shared memory port.
REQ-007 SHALL have port stall_req_o  output  1  pipeline stall request to the stall controller.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, DONE, with a 4-bit wait counter and a 1-bit granted-port register.
REQ-009 In IDLE with any request asserted, the block SHALL latch grant, address, we, sel and wdata, load counter with WAIT_CYCLES, and go to ACCESS. In IDLE with no request, it SHALL stay in IDLE.
REQ-010 Arbitration: when both requests are asserted in IDLE, data SHALL win over fetch (fixed priority; see REQ-021).
REQ-011 In ACCESS, bus_ce_o SHALL be 1 and the bus outputs SHALL be driven only from latched values. If counter is 0, go to DONE; otherwise decrement.
REQ-012 On the last ACCESS cycle (counter 0) of a read, bus_rdata_i SHALL be captured into the granted port's data register. Fetches are always reads; a fetch SHALL drive bus_we_o=0 and bus_sel_o=4'b1111.
REQ-013 In DONE, the granted port's ready SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE. Arbitration happens only in IDLE, so there is one idle bubble between accesses.
REQ-014 Latency: request first sampled in IDLE at cycle 0 gives ready at cycle WAIT_CYCLES+2.
REQ-015 Outside ACCESS, bus_ce_o, bus_we_o and bus_sel_o SHALL be 0; bus_addr_o and bus_wdata_o are don't-care but SHALL be 0.
REQ-016 if_data_o and d_rdata_o SHALL hold their last captured value until the next read for that port; writes SHALL leave d_rdata_o unchanged.
REQ-017 stall_req_o SHALL equal (if_req_i & ~if_ready_o) | (d_req_i & ~d_ready_o).
REQ-018 Requesters SHALL hold req and operands until ready. If req is dropped mid-access, the access SHALL complete and ready SHALL still pulse. Input changes during ACCESS SHALL have no effect on the bus.
REQ-019 WAIT_CYCLES=0 SHALL give exactly one ACCESS cycle.

Reset
REQ-020 While rst=0, immediately and regardless of clk: state IDLE, counter 0, all outputs 0, both data registers 0, last-grant register = fetch. An access interrupted by reset SHALL be abandoned with no ready pulse.

Configuration
REQ-021 Macro MEM_BUS_ARB_RR_EN:
- Defined: when both requests are asserted, grant the port not granted last; the last-grant register updates on every grant.
- Undefined: fixed data-over-fetch priority, and the last-grant register is absent.

Verification
REQ-022 Single fetch: WAIT_CYCLES=2, if_req_i=1, if_addr_i=0x100, bus_rdata_i=0x3C010001 -> bus_ce_o=1 for cycles 1-3, if_ready_o=1 at cycle 4 only, if_data_o=0x3C010001, stall_req_o=1 for cycles 0-3.
REQ-023 Data store: d_we_i=1, d_addr_i=0x40, d_sel_i=4'b0011, d_wdata_i=0xBEEF -> bus_we_o=1, bus_sel_o=4'b0011 during ACCESS, d_ready_o pulse at cycle 4, d_rdata_o unchanged.
REQ-024 Contention: both requests asserted at cycle 0.
- Without the macro: data served first (ready at cycle 4), fetch ready at cycle 9.
- With the macro, after a prior data grant: fetch served first.
REQ-025 Reset mid-access: rst=0 at ACCESS cycle 2 -> bus_ce_o=0 immediately, no ready pulse, and a new fetch after release completes normally at latency WAIT_CYCLES+2.
REQ-026 WAIT_CYCLES=0: load from 0x80 with bus_rdata_i=0x12345678 -> one ACCESS cycle, d_ready_o at cycle 2, d_rdata_o=0x12345678.
